// File: rtl/apb_slave_regfile_if.sv
// rtl/apb_slave_regfile_if.sv - 8-bit APB bus signals between the apb_master and a register-file completer
interface apb_slave_regfile_if;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       pready;
  logic       pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - APB completer serving a DEPTH x 8-bit register file, fixed wait states and a read-only ID
module apb_slave_regfile #(
  parameter int         DEPTH       = 16,
  parameter int         WAIT_STATES = 0,
  parameter logic [7:0] ID_VALUE    = 8'hA5
) (
  input logic               pclk,
  input logic               prst,
  apb_slave_regfile_if.slave apb
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WS      = 4'(WAIT_STATES);
  localparam logic [8:0] DEPTH9  = 9'(DEPTH);
  localparam logic [7:0] ID_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pready_q;

  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic       write_q;
  logic       in_range_q;
  logic       err_q;

  logic [7:0] regs [DEPTH];

  logic          setup;
  logic          take;
  logic          in_range_bus;
  logic          err_bus;
  logic [AW-1:0] idx;
  logic [7:0]    rdata_mux;

  assign setup        = apb.psel & ~apb.penable;
  assign in_range_bus = {1'b0, apb.paddr} < DEPTH9;
  // Out-of-range addresses error, except reads of the ID location
  assign err_bus      = ~in_range_bus & ((apb.paddr != ID_ADDR) | apb.pwrite);
  assign idx          = addr_q[AW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          take = 1'b1;
        end
      end
      S_WAIT: begin
        if (!apb.psel) begin
          state_d = S_IDLE;
        end else if (apb.penable) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (setup) begin
          take = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (take) begin
      cnt_d   = WS;
      state_d = (WS == 4'd0) ? S_RESP : S_WAIT;
    end
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pready_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      in_range_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= (state_d == S_RESP);
      if (take) begin
        addr_q     <= apb.paddr;
        wdata_q    <= apb.pwdata;
        write_q    <= apb.pwrite;
        in_range_q <= in_range_bus;
        err_q      <= err_bus;
      end
    end
  end

  // Commit happens on the edge that ends the pready cycle, from latched fields only
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (pready_q && write_q && in_range_q) begin
      regs[idx] <= wdata_q;
    end
  end

  always_comb begin
    rdata_mux = '0;
    if (in_range_q) begin
      rdata_mux = regs[idx];
    end else if (addr_q == ID_ADDR) begin
      rdata_mux = ID_VALUE;
    end
  end

  assign apb.pready  = pready_q;
  assign apb.pslverr = pready_q & err_q;
  assign apb.prdata  = (pready_q & ~write_q) ? rdata_mux : 8'h00;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// tb/tb_apb_slave_regfile.sv - bench for apb_slave_regfile with zero and three wait states
module tb_apb_slave_regfile;

  localparam logic [7:0] ID = 8'hA5;

  logic pclk = 1'b0;
  logic prst = 1'b1;
  always #5 pclk = ~pclk;

  logic [1:0] m_psel    = '0;
  logic [1:0] m_penable = '0;
  logic [1:0] m_pwrite  = '0;
  logic [7:0] m_paddr  [2];
  logic [7:0] m_pwdata [2];
  logic [1:0] s_pready;
  logic [1:0] s_pslverr;
  logic [7:0] s_prdata [2];

  apb_slave_regfile_if bus0 ();
  apb_slave_regfile_if bus3 ();

  assign bus0.psel    = m_psel[0];
  assign bus0.penable = m_penable[0];
  assign bus0.pwrite  = m_pwrite[0];
  assign bus0.paddr   = m_paddr[0];
  assign bus0.pwdata  = m_pwdata[0];
  assign bus3.psel    = m_psel[1];
  assign bus3.penable = m_penable[1];
  assign bus3.pwrite  = m_pwrite[1];
  assign bus3.paddr   = m_paddr[1];
  assign bus3.pwdata  = m_pwdata[1];
  assign s_pready[0]  = bus0.pready;
  assign s_pslverr[0] = bus0.pslverr;
  assign s_prdata[0]  = bus0.prdata;
  assign s_pready[1]  = bus3.pready;
  assign s_pslverr[1] = bus3.pslverr;
  assign s_prdata[1]  = bus3.prdata;

  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(0), .ID_VALUE(8'hA5)) dut0 (
    .pclk(pclk), .prst(prst), .apb(bus0.slave)
  );
  apb_slave_regfile #(.DEPTH(16), .WAIT_STATES(3), .ID_VALUE(8'hA5)) dut3 (
    .pclk(pclk), .prst(prst), .apb(bus3.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] mregs [2][16];

  typedef struct {
    int         d;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] data;
    logic       b2b;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t vecs [14];

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %02h expected %02h", name, act, exp);
  endtask

  task automatic checkn(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) mregs[d][i] = 8'h00;
  endtask

  // Reference: decode address classes, then commit writes into the model array
  task automatic model(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                       output logic [7:0] rd, output logic err);
    rd  = 8'h00;
    err = 1'b0;
    if (addr < 16) begin
      if (wr) mregs[d][addr[3:0]] = data;
      else    rd = mregs[d][addr[3:0]];
    end else if (addr == 8'hFF) begin
      if (wr) err = 1'b1;
      else    rd = ID;
    end else begin
      err = 1'b1;
    end
  endtask

  task automatic bus_idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge pclk); #1;
      m_psel    = '0;
      m_penable = '0;
      @(negedge pclk);
      check1("idle_pready0", s_pready[0], 1'b0);
      check1("idle_pready3", s_pready[1], 1'b0);
    end
  endtask

  task automatic xfer(input int d, input logic wr, input logic [7:0] addr, input logic [7:0] data,
                      input bit scramble, output logic [7:0] rdata, output logic err,
                      output int waits, output bit ok);
    ok = 0; waits = 0; rdata = 8'h00; err = 1'b0;
    @(posedge pclk); #1;
    m_psel[d] = 1'b1; m_penable[d] = 1'b0; m_pwrite[d] = wr;
    m_paddr[d] = addr; m_pwdata[d] = data;
    @(negedge pclk);
    check1("setup_pready", s_pready[d], 1'b0);
    @(posedge pclk); #1;
    m_penable[d] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (scramble) begin
        m_paddr[d]  = 8'($urandom);
        m_pwdata[d] = 8'($urandom);
        m_pwrite[d] = 1'($urandom);
      end
      @(negedge pclk);
      if (s_pready[d]) begin
        rdata = s_prdata[d];
        err   = s_pslverr[d];
        ok    = 1;
        break;
      end
      check1("wait_pslverr", s_pslverr[d], 1'b0);
      waits++;
      @(posedge pclk); #1;
    end
    checkn("xfer_done", int'(ok), 1);
  endtask

  task automatic checked_xfer(input int d, input logic wr, input logic [7:0] addr,
                              input logic [7:0] data, input bit scramble);
    logic [7:0] erd, rd;
    logic       eerr, err;
    int         waits;
    bit         ok;
    model(d, wr, addr, data, erd, eerr);
    xfer(d, wr, addr, data, scramble, rd, err, waits, ok);
    if (ok) begin
      check1("rand_pslverr", err, eerr);
      if (!wr) check8("rand_prdata", rd, erd);
      checkn("rand_waits", waits, ws_of(d));
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic       err;
    int         waits;
    bit         ok;
    int         prev_d;

    m_paddr[0] = '0; m_paddr[1] = '0; m_pwdata[0] = '0; m_pwdata[1] = '0;
    model_clear();

    vecs[0]  = '{0, 1'b1, 8'h05, 8'h3C, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{0, 1'b0, 8'h05, 8'h00, 1'b0, 8'h3C, 1'b0};
    vecs[2]  = '{0, 1'b1, 8'h20, 8'h11, 1'b0, 8'h00, 1'b1};
    vecs[3]  = '{0, 1'b0, 8'h20, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{0, 1'b1, 8'hFF, 8'h5A, 1'b0, 8'h00, 1'b1};
    vecs[5]  = '{0, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b0};
    vecs[6]  = '{0, 1'b1, 8'h01, 8'h01, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{0, 1'b1, 8'h02, 8'h02, 1'b1, 8'h00, 1'b0};
    vecs[8]  = '{0, 1'b0, 8'h01, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[9]  = '{0, 1'b0, 8'h02, 8'h00, 1'b1, 8'h02, 1'b0};
    vecs[10] = '{0, 1'b0, 8'h0F, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{0, 1'b0, 8'h10, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[12] = '{0, 1'b0, 8'hFE, 8'h00, 1'b0, 8'h00, 1'b1};
    vecs[13] = '{1, 1'b0, 8'hFF, 8'h00, 1'b0, 8'hA5, 1'b0};

    repeat (2) @(negedge pclk);
    for (int d = 0; d < 2; d++) begin
      check1("rst_pready", s_pready[d], 1'b0);
      check1("rst_pslverr", s_pslverr[d], 1'b0);
      check8("rst_prdata", s_prdata[d], 8'h00);
    end
    prst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      logic [7:0] mrd;
      logic       merr;
      if (!vecs[i].b2b) bus_idle(1);
      model(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, mrd, merr);
      xfer(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].data, 1'b0, rd, err, waits, ok);
      if (ok) begin
        check1("vec_pslverr", err, vecs[i].exp_err);
        if (!vecs[i].wr) check8("vec_prdata", rd, vecs[i].exp_rd);
        checkn("vec_waits", waits, ws_of(vecs[i].d));
      end
    end
    bus_idle(1);

    // penable without SETUP must not start a transfer
    for (int c = 0; c < 3; c++) begin
      @(posedge pclk); #1;
      m_psel[0] = 1'b1; m_penable[0] = 1'b1;
      @(negedge pclk);
      check1("noset_pready", s_pready[0], 1'b0);
    end
    bus_idle(1);

    // Master abort during WAIT of a write to reg 3
    checked_xfer(1, 1'b1, 8'h03, 8'h33, 1'b0);
    bus_idle(1);
    @(posedge pclk); #1;
    m_psel[1] = 1'b1; m_penable[1] = 1'b0; m_pwrite[1] = 1'b1;
    m_paddr[1] = 8'h03; m_pwdata[1] = 8'hEE;
    @(posedge pclk); #1;
    m_penable[1] = 1'b1;
    @(negedge pclk);
    check1("abort_wait_pready", s_pready[1], 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge pclk); #1;
      m_psel[1] = 1'b0; m_penable[1] = 1'b0;
      @(negedge pclk);
      check1("abort_pready", s_pready[1], 1'b0);
      check1("abort_pslverr", s_pslverr[1], 1'b0);
    end
    xfer(1, 1'b0, 8'h03, 8'h00, 1'b0, rd, err, waits, ok);
    check8("abort_reg3", rd, 8'h33);
    bus_idle(1);

    // Reset while pready=1 on dut0
    xfer(0, 1'b0, 8'hFF, 8'h00, 1'b0, rd, err, waits, ok);
    check8("pre_rst_id", rd, ID);
    #1 prst = 1'b1;
    #1;
    check1("rst_resp_pready", s_pready[0], 1'b0);
    check8("rst_resp_prdata", s_prdata[0], 8'h00);
    m_psel = '0; m_penable = '0;
    @(negedge pclk);
    prst = 1'b0;
    model_clear();
    bus_idle(1);

    // Reset mid-WAIT of a write on dut3
    checked_xfer(1, 1'b1, 8'h04, 8'h77, 1'b0);
    bus_idle(1);
    @(posedge pclk); #1;
    m_psel[1] = 1'b1; m_penable[1] = 1'b0; m_pwrite[1] = 1'b1;
    m_paddr[1] = 8'h05; m_pwdata[1] = 8'h99;
    @(posedge pclk); #1;
    m_penable[1] = 1'b1;
    @(negedge pclk);
    #2 prst = 1'b1;
    #1;
    check1("rst_wait_pready", s_pready[1], 1'b0);
    check1("rst_wait_pslverr", s_pslverr[1], 1'b0);
    check8("rst_wait_prdata", s_prdata[1], 8'h00);
    m_psel = '0; m_penable = '0;
    @(negedge pclk);
    prst = 1'b0;
    model_clear();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) begin
        bus_idle(1);
        xfer(d, 1'b0, 8'(a), 8'h00, 1'b0, rd, err, waits, ok);
        check8("post_rst_reg", rd, 8'h00);
      end
    end

    prev_d = -1;
    for (int n = 0; n < 200; n++) begin
      int         d, r;
      logic       wr;
      logic [7:0] addr;
      d  = $urandom_range(0, 1);
      wr = 1'($urandom);
      r  = $urandom_range(0, 99);
      if (r < 60)      addr = 8'($urandom_range(0, 15));
      else if (r < 75) addr = 8'hFF;
      else             addr = 8'($urandom_range(16, 254));
      if (d != prev_d || $urandom_range(0, 2) == 0) bus_idle($urandom_range(1, 2));
      checked_xfer(d, wr, addr, 8'($urandom), 1'b1);
      prev_d = d;
    end
    bus_idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
